// File: rtl/coin_start_pkg.sv
// Shared types and constants for the coin/start pulse sequencer.
// Holds the FSM state encoding, player-select encoding and counter width.
package coin_start_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COIN  = 3'd1,
        ST_GAP   = 3'd2,
        ST_START = 3'd3,
        ST_COOL  = 3'd4
    } state_e;

    typedef enum logic {
        SEL_P1 = 1'b0,
        SEL_P2 = 1'b1
    } sel_e;

    // A phase ends on the tick seen while the counter still reads 1.
    function automatic logic last_frame(input logic [CNT_W-1:0] cnt);
        return (cnt <= CNT_W'(1));
    endfunction

endpackage

// File: rtl/coin_start_seq_rise_edge.sv
// Registered rising-edge detector: flags the cycle where the input goes 0 -> 1.
// The history flop clears on reset, so a level held through reset yields one edge.
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic lvl_d;
    logic lvl_q;

    always_comb begin
        lvl_d = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    assign rise = d & ~lvl_q;

endmodule

// File: rtl/coin_start_seq.sv
// Turns player start requests into a timed coin pulse followed by a start pulse,
// with all phase lengths counted in video frames (vblank rising edges).
module coin_start_seq
    import coin_start_pkg::*;
#(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 8,
    parameter int START_FRAMES = 4,
    parameter int COOL_FRAMES  = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic I_VBLANK,
    input  logic I_START1,
    input  logic I_START2,
    output logic O_COIN,
    output logic O_START1,
    output logic O_START2,
    output logic O_BUSY
);

    localparam logic [CNT_W-1:0] COIN_LD  = CNT_W'(COIN_FRAMES);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_FRAMES);
    localparam logic [CNT_W-1:0] START_LD = CNT_W'(START_FRAMES);
    localparam logic [CNT_W-1:0] COOL_LD  = CNT_W'(COOL_FRAMES);

    logic tick;
    logic rise1;
    logic rise2;

    rise_edge u_vblank_edge (
        .clk  (CLK),
        .rst  (RESET),
        .d    (I_VBLANK),
        .rise (tick)
    );

    rise_edge u_start1_edge (
        .clk  (CLK),
        .rst  (RESET),
        .d    (I_START1),
        .rise (rise1)
    );

    rise_edge u_start2_edge (
        .clk  (CLK),
        .rst  (RESET),
        .d    (I_START2),
        .rise (rise2)
    );

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    sel_e             sel_d, sel_q;
    logic             pend1_d, pend1_q;
    logic             pend2_d, pend2_q;
    logic             o_coin_d, o_coin_q;
    logic             o_start1_d, o_start1_q;
    logic             o_start2_d, o_start2_q;
    logic             o_busy_d, o_busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        // Pending bits are sticky; a repeat edge on an already-set bit is a no-op.
        pend1_d = pend1_q | rise1;
        pend2_d = pend2_q | rise2;

        case (state_q)
            ST_IDLE: begin
                if (pend1_q || pend2_q) begin
                    state_d = ST_COIN;
                    cnt_d   = COIN_LD;
                    if (pend1_q) begin
                        sel_d   = SEL_P1;
                        pend1_d = 1'b0;
                    end else begin
                        sel_d   = SEL_P2;
                        pend2_d = 1'b0;
                    end
                end
            end
            ST_COIN: begin
                if (tick) begin
                    if (last_frame(cnt_q)) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (last_frame(cnt_q)) begin
                        state_d = ST_START;
                        cnt_d   = START_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_START: begin
                if (tick) begin
                    if (last_frame(cnt_q)) begin
                        state_d = ST_COOL;
                        cnt_d   = COOL_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_COOL: begin
                if (tick) begin
                    if (last_frame(cnt_q)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registered copy lines up with it.
        o_coin_d   = (state_d == ST_COIN);
        o_start1_d = (state_d == ST_START) && (sel_d == SEL_P1);
        o_start2_d = (state_d == ST_START) && (sel_d == SEL_P2);
        o_busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sel_q      <= SEL_P1;
            pend1_q    <= 1'b0;
            pend2_q    <= 1'b0;
            o_coin_q   <= 1'b0;
            o_start1_q <= 1'b0;
            o_start2_q <= 1'b0;
            o_busy_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            pend1_q    <= pend1_d;
            pend2_q    <= pend2_d;
            o_coin_q   <= o_coin_d;
            o_start1_q <= o_start1_d;
            o_start2_q <= o_start2_d;
            o_busy_q   <= o_busy_d;
        end
    end

    assign O_COIN   = o_coin_q;
    assign O_START1 = o_start1_q;
    assign O_START2 = o_start2_q;
    assign O_BUSY   = o_busy_q;

endmodule

// File: tb/tb_coin_start_seq.sv
// Bench for coin_start_seq: a default-parameter and an all-ones instance share stimulus,
// each checked every cycle against a frame-count model of the sequence timeline.
module tb_coin_start_seq;

    logic       CLK;
    logic       RESET;
    logic       I_VBLANK;
    logic       I_START1;
    logic       I_START2;
    logic [1:0] o_coin;
    logic [1:0] o_start1;
    logic [1:0] o_start2;
    logic [1:0] o_busy;

    coin_start_seq dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .I_VBLANK (I_VBLANK),
        .I_START1 (I_START1),
        .I_START2 (I_START2),
        .O_COIN   (o_coin[0]),
        .O_START1 (o_start1[0]),
        .O_START2 (o_start2[0]),
        .O_BUSY   (o_busy[0])
    );

    coin_start_seq #(
        .COIN_FRAMES  (1),
        .GAP_FRAMES   (1),
        .START_FRAMES (1),
        .COOL_FRAMES  (1)
    ) dut1 (
        .CLK      (CLK),
        .RESET    (RESET),
        .I_VBLANK (I_VBLANK),
        .I_START1 (I_START1),
        .I_START2 (I_START2),
        .O_COIN   (o_coin[1]),
        .O_START1 (o_start1[1]),
        .O_START2 (o_start2[1]),
        .O_BUSY   (o_busy[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_tests = 0;
    int n_fail  = 0;
    string cur_tag = "reset";

    int prm_c [2] = '{4, 1};
    int prm_g [2] = '{8, 1};
    int prm_s [2] = '{4, 1};
    int prm_k [2] = '{2, 1};

    // Model: each instance is either idle or some number of frames into its sequence.
    bit m_busy [2];
    int m_el   [2];
    int m_pl   [2];
    bit m_p1   [2];
    bit m_p2   [2];
    bit pv, ps1, ps2;

    bit hold_s1, hold_s2, rnd_mode;
    bit last_s2;
    int s2_pulses;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_el[k]   = 0;
            m_pl[k]   = 1;
            m_p1[k]   = 1'b0;
            m_p2[k]   = 1'b0;
        end
        pv  = 1'b0;
        ps1 = 1'b0;
        ps2 = 1'b0;
    endtask

    task automatic model_edge(input bit vb, input bit s1, input bit s2);
        bit tick, r1, r2, sv1, sv2;
        int total;
        tick = vb && !pv;
        r1   = s1 && !ps1;
        r2   = s2 && !ps2;
        for (int k = 0; k < 2; k++) begin
            total = prm_c[k] + prm_g[k] + prm_s[k] + prm_k[k];
            sv1 = 1'b0;
            sv2 = 1'b0;
            if (m_busy[k]) begin
                if (tick) begin
                    m_el[k]++;
                    if (m_el[k] == total) m_busy[k] = 1'b0;
                end
            end else if (m_p1[k] || m_p2[k]) begin
                m_busy[k] = 1'b1;
                m_el[k]   = 0;
                if (m_p1[k]) begin
                    m_pl[k] = 1;
                    sv1 = 1'b1;
                end else begin
                    m_pl[k] = 2;
                    sv2 = 1'b1;
                end
            end
            m_p1[k] = (m_p1[k] || r1) && !sv1;
            m_p2[k] = (m_p2[k] || r2) && !sv2;
        end
        pv  = vb;
        ps1 = s1;
        ps2 = s2;
    endtask

    function automatic logic [3:0] model_out(input int k);
        bit coin, st;
        coin = m_busy[k] && (m_el[k] < prm_c[k]);
        st   = m_busy[k] && (m_el[k] >= prm_c[k] + prm_g[k])
                         && (m_el[k] <  prm_c[k] + prm_g[k] + prm_s[k]);
        return {coin, st && (m_pl[k] == 1), st && (m_pl[k] == 2), m_busy[k]};
    endfunction

    task automatic check_all(input string tag);
        logic [3:0] got, exp;
        for (int k = 0; k < 2; k++) begin
            exp = model_out(k);
            got = {o_coin[k], o_start1[k], o_start2[k], o_busy[k]};
            n_tests++;
            assert (got === exp) else begin
                n_fail++;
                $error("FAIL %s dut%0d t=%0t {coin,s1,s2,busy} got=%b exp=%b", tag, k, $time, got, exp);
            end
        end
        if (o_start2[0] === 1'b1 && !last_s2) s2_pulses++;
        last_s2 = (o_start2[0] === 1'b1);
    endtask

    task automatic cyc(input bit vb, input bit s1, input bit s2);
        I_VBLANK = vb;
        I_START1 = s1;
        I_START2 = s2;
        @(posedge CLK);
        if (RESET) model_reset();
        else       model_edge(vb, s1, s2);
        @(negedge CLK);
        check_all(cur_tag);
    endtask

    task automatic frames(input int n);
        int hi, lo;
        for (int f = 0; f < n; f++) begin
            hi = int'($urandom_range(1, 3));
            lo = int'($urandom_range(2, 4));
            for (int i = 0; i < hi + lo; i++) begin
                if (rnd_mode) begin
                    if ($urandom_range(0, 11) == 0) hold_s1 = !hold_s1;
                    if ($urandom_range(0, 11) == 0) hold_s2 = !hold_s2;
                end
                cyc(i < hi, hold_s1, hold_s2);
            end
        end
    endtask

    task automatic async_reset(input bit s1);
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        cyc(1'b0, s1, 1'b0);
        cyc(1'b0, s1, 1'b0);
        RESET = 1'b0;
    endtask

    initial begin
        RESET    = 1'b1;
        I_VBLANK = 1'b0;
        I_START1 = 1'b0;
        I_START2 = 1'b0;
        hold_s1  = 1'b0;
        hold_s2  = 1'b0;
        rnd_mode = 1'b0;
        last_s2  = 1'b0;
        s2_pulses = 0;
        model_reset();
        @(negedge CLK);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        RESET = 1'b0;

        cur_tag = "single_p1";
        cyc(1'b0, 1'b1, 1'b0);
        frames(22);

        cur_tag = "both_same_cycle";
        cyc(1'b0, 1'b1, 1'b1);
        frames(42);

        cur_tag = "p2_repeat_in_gap";
        s2_pulses = 0;
        cyc(1'b0, 1'b0, 1'b1);
        frames(7);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
        end
        frames(45);
        n_tests++;
        assert (s2_pulses == 2) else begin
            n_fail++;
            $error("FAIL p2_seq_count got=%0d exp=2", s2_pulses);
        end

        cur_tag = "held_vblank";
        cyc(1'b0, 1'b1, 1'b0);
        frames(3);
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        frames(25);

        cur_tag = "reset_in_start";
        cyc(1'b0, 1'b1, 1'b0);
        frames(15);
        n_tests++;
        assert (o_start1[0] === 1'b1) else begin
            n_fail++;
            $error("FAIL start1_before_reset got=%b exp=1", o_start1[0]);
        end
        async_reset(1'b0);
        frames(25);
        n_tests++;
        assert (o_busy[0] === 1'b0) else begin
            n_fail++;
            $error("FAIL idle_after_reset got=%b exp=0", o_busy[0]);
        end

        cur_tag = "held_through_reset";
        cyc(1'b0, 1'b1, 1'b0);
        async_reset(1'b1);
        hold_s1 = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        frames(3);
        hold_s1 = 1'b0;
        frames(22);

        cur_tag = "random";
        rnd_mode = 1'b1;
        frames(400);
        rnd_mode = 1'b0;
        hold_s1 = 1'b0;
        hold_s2 = 1'b0;
        frames(45);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_start_seq.md
COIN_START_SEQ -- requirements
Module: coin_start_seq

Interface
REQ-001 SHALL have parameter COIN_FRAMES, default 4, meaning frames O_COIN is held high; legal range 1..255.
REQ-002 SHALL have parameter GAP_FRAMES, default 8, meaning frames between coin release and start assertion; legal range 1..255.
REQ-003 SHALL have parameter START_FRAMES, default 4, meaning frames O_START1/O_START2 is held high; legal range 1..255.
REQ-004 SHALL have parameter COOL_FRAMES, default 2, meaning idle frames after start release before the next sequence; legal range 1..255.
REQ-005 SHALL have port CLK, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port I_VBLANK, input, 1 bit: video vblank level, synchronous to CLK; its rising edge is the frame tick.
REQ-008 SHALL have ports I_START1 and I_START2, input, 1 bit each: raw player start request levels.
REQ-009 SHALL have port O_COIN, output, 1 bit: coin pulse to the game core, active-high.
REQ-010 SHALL have ports O_START1 and O_START2, output, 1 bit each: start button pulses to the game core, active-high.
REQ-011 SHALL have port O_BUSY, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL register I_VBLANK; tick = I_VBLANK & ~I_VBLANK_q. One tick per frame; a held vblank level produces no further ticks.
REQ-013 SHALL detect rising edges of I_START1 and I_START2 and set sticky pending bits pend1 and pend2. A held level sets the bit once only.
REQ-014 SHALL ignore a new request edge for a player whose pending bit is already set. No request counting; maximum one pending per player.
REQ-015 SHALL use FSM states IDLE, COIN, GAP, START and COOL, plus an 8-bit frame counter and a 1-bit served-player register sel.
REQ-016 IDLE: when pend1 or pend2 is set, SHALL go to COIN on the next CLK. SHALL set sel=P1 if pend1 is set, otherwise P2; P1 wins a simultaneous request. SHALL load the counter with COIN_FRAMES and clear the selected pending bit in the same cycle.
REQ-017 COIN: O_COIN=1. SHALL decrement the counter on each tick. On the tick that takes the counter from 1 to 0, SHALL go to GAP and load GAP_FRAMES.
REQ-018 GAP: all outputs low. SHALL use the same decrement and exit rule as COIN, then go to START and load START_FRAMES.
REQ-019 START: O_START1=(sel==P1) and O_START2=(sel==P2). SHALL use the same exit rule, then go to COOL and load COOL_FRAMES.
REQ-020 COOL: all outputs low. SHALL use the same exit rule, then go to IDLE. A pending request is taken from IDLE on the following cycle.
REQ-021 Pulse lengths SHALL be exact: each phase lasts exactly N ticks. Phase boundaries change on the CLK edge after the tick cycle.
REQ-022 All outputs SHALL be registered; O_COIN, O_START1 and O_START2 are never high simultaneously.
REQ-023 Request edges that arrive during any non-IDLE state SHALL be captured into the pending bits and served later. The same player's request during its own sequence queues one repeat.
REQ-024 A tick coincident with the IDLE->COIN transition SHALL NOT decrement; counting starts the cycle after entry.

Reset
REQ-025 RESET SHALL asynchronously force state=IDLE, counter=0, sel=P1, pend1=pend2=0, edge-detect registers=0 and all outputs=0.
REQ-026 RESET asserted mid-sequence SHALL abort immediately. Outputs drop in the same assertion with no completion of the pulse.
REQ-027 Edge-detect registers reset to 0. An input held high through reset release SHALL therefore register one request edge on the first CLK after release.

Structure
REQ-028 State enum, player-select encoding and an 8-bit counter width constant SHALL live in shared package coin_start_pkg.
REQ-029 The design SHALL be single module; one optional sub-module rise_edge (registered rising-edge detector, instantiated three times) is natural.

Verification
REQ-030 Scenario: defaults; pulse I_START1 once, then 20 ticks. Required: O_COIN high exactly 4 ticks, low 8 ticks, then O_START1 high exactly 4 ticks; O_START2 never high; then O_BUSY low after 2 more ticks.
REQ-031 Scenario: I_START1 and I_START2 rise in the same cycle. Required: the full P1 sequence first; after COOL, the P2 sequence (coin 4, gap 8, O_START2 4) with no extra stimulus.
REQ-032 Scenario: I_START2 pulsed three times during the GAP of a P2 sequence. Required: exactly one additional P2 sequence follows, not three.
REQ-033 Scenario: RESET asserted at tick 2 of START. Required: O_START1 drops asynchronously, O_BUSY=0, and no further pulses after reset release with inputs low.
REQ-034 Scenario: I_VBLANK held high 100 cycles during COIN. Required: counter decrements by exactly 1.
REQ-035 Scenario: COIN_FRAMES=1, GAP_FRAMES=1, START_FRAMES=1, COOL_FRAMES=1. Required: each phase lasts exactly one tick; total sequence is 4 ticks.
